// File: rtl/bin2dec_digits.sv
// bin2dec_digits: sequential binary-to-BCD converter (shift-and-add-3) that
// produces eight 6-bit digit codes for the seven-segment driver. It supports
// optional leading-zero blanking and shows dashes on overflow. The outputs
// are registered and only change on a LOAD edge or on reset.
module bin2dec_digits #(
    parameter int           BIN_W      = 27,
    parameter logic [5:0]   BLANK_CODE = 6'h3F,
    parameter logic [5:0]   DASH_CODE  = 6'h3E
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             lead_blank,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [5:0]       d0,
    output logic [5:0]       d1,
    output logic [5:0]       d2,
    output logic [5:0]       d3,
    output logic [5:0]       d4,
    output logic [5:0]       d5,
    output logic [5:0]       d6,
    output logic [5:0]       d7
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam logic [31:0] MAX_VAL = 32'd99_999_999;
    localparam logic [5:0]  LAST    = 6'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [31:0]        bcd_q, bcd_d;
    logic               blank_q, blank_d;
    logic               ovfc_q, ovfc_d;      // overflow flag captured at start
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [7:0][5:0]    dig_q, dig_d;

    logic [31:0]        bcd_adj;
    logic [7:0][5:0]    dig_map;
    logic               seen_nz;

    // add 3 to every BCD nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 8; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // map the final BCD onto digit codes; blank every digit above the top nonzero nibble
    always_comb begin
        dig_map    = '0;
        seen_nz    = 1'b0;
        dig_map[0] = {2'b00, bcd_q[3:0]};
        for (int k = 7; k >= 1; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0)
                seen_nz = 1'b1;
            dig_map[k] = (blank_q && !seen_nz) ? BLANK_CODE : {2'b00, bcd_q[4*k +: 4]};
        end
    end

    // next-state and datapath control for IDLE -> SHIFT x BIN_W -> LOAD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovfc_d  = ovfc_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    blank_d = lead_blank;
                    ovfc_d  = (32'(bin_in) > MAX_VAL);
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[30:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST)
                    state_d = LOAD;
            end
            LOAD: begin
                done_d  = 1'b1;
                ovf_d   = ovfc_q;
                dig_d   = ovfc_q ? {8{DASH_CODE}} : dig_map;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            blank_q <= 1'b0;
            ovfc_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            ovfc_q  <= ovfc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign d0   = dig_q[0];
    assign d1   = dig_q[1];
    assign d2   = dig_q[2];
    assign d3   = dig_q[3];
    assign d4   = dig_q[4];
    assign d5   = dig_q[5];
    assign d6   = dig_q[6];
    assign d7   = dig_q[7];

endmodule

// File: doc/bin2dec_digits.md
Name: bin2dec_digits

Overview:
- Sequential binary-to-decimal converter that produces the eight 6-bit digit codes feeding the seven-segment driver's in0..in7 inputs.
- Captures an unsigned binary value on a start pulse and runs a shift-and-add-3 (double-dabble) sequence, one bit per clock.
- Applies optional leading-zero blanking and holds the result on registered outputs, so the display never shows intermediate values.

Parameters:
- BIN_W, 27: width of the binary input. Legal range 27..32. Values above 99_999_999 are overflow.
- BLANK_CODE, 6'h3F: digit code for an unlit digit.
- DASH_CODE, 6'h3E: digit code for a dash, used on overflow.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle conversion request; ignored while busy=1.
- bin_in  in  BIN_W  unsigned value to convert; sampled only on an accepted start.
- lead_blank  in  1  1 = blank leading zeros; sampled with bin_in.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when d0..d7 update.
- ovf  out  1  high if the last conversion was out of range; held until the next done.
- d0..d7  out  6 each  digit codes, d0 = least significant. Values 0..9 are decimal digits; other values are BLANK_CODE or DASH_CODE.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE.
  - busy=0, done=0, ovf=0, all d0..d7 = 6'd0.
  - Internal shift register and BCD accumulator are cleared.
  - Reset aborts any conversion in progress. Outputs take their reset values, and the aborted conversion never produces a done.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - start=1 at edge E0 captures bin_in and lead_blank.
  - At the same edge: BCD accumulator (32 bits, 8 nibbles) cleared, bit counter = 0, next state SHIFT, busy=1.
  - The overflow compare (captured value > 99_999_999) is evaluated at E0 and latched internally.
- SHIFT, once per edge E1..E_BIN_W:
  - Every BCD nibble >= 5 gets 3 added to it.
  - The {BCD, binary} vector then shifts left by 1, moving the binary MSB into BCD bit 0.
  - Bit counter increments. On the edge where the counter reaches BIN_W-1, next state is LOAD.
  - The adjust and the shift happen in the same cycle.
- LOAD, edge E_(BIN_W+1):
  - d0..d7 are written and ovf is updated.
  - done=1 for exactly one cycle and busy returns to 0 (both visible after this edge).
  - Next state is IDLE.
- Latency: start sampled at E0, outputs valid and done high after E_(BIN_W+1). Default is 28 cycles. Latency is the same for every input, including overflow.
- Digit mapping:
  - Without blanking: d[k] = {2'b00, nibble k}.
  - With lead_blank=1: every digit above the most significant nonzero nibble becomes BLANK_CODE.
  - d0 is never blanked, so value 0 shows a single "0".
- Overflow: all d0..d7 = DASH_CODE and ovf=1, regardless of lead_blank. The BCD contents are discarded.
- start while busy=1 is ignored. It is not queued.
- start in the same cycle as done (FSM already in IDLE the next cycle) is accepted normally. Back-to-back conversions are allowed with start on the cycle after done.
- Changing bin_in or lead_blank during a conversion has no effect.
- d0..d7 and ovf change only on a LOAD edge or on reset. They stay stable between conversions.

Test Plan:
1. Reset, then start with bin_in=12_345_678, lead_blank=0 -> done exactly 28 cycles after the start edge. d7..d0 = 1,2,3,4,5,6,7,8; ovf=0; busy high for 28 cycles.
2. bin_in=305: with lead_blank=0 -> d7..d0 = 0,0,0,0,0,3,0,5. With lead_blank=1 -> d7..d3 = 6'h3F, d2=3, d1=0, d0=5.
3. bin_in=0, lead_blank=1 -> d0=0, d1..d7 = 6'h3F. Then bin_in=99_999_999 -> all digits 9, ovf=0.
4. bin_in=100_000_000 -> after 28 cycles all d = 6'h3E, ovf=1. Next conversion of 42 -> ovf=0, d1=4, d0=2.
5. Start pulse and bin_in change during busy -> ignored; result matches the first captured value and only one done pulse occurs.
6. rst asserted at cycle 10 of a conversion -> next cycle busy=0, all d=0, and no done pulse. A new start after reset converts correctly.
